// File: rtl/dadd_mc_core.sv
// Multi-channel add unit: each channel adds its programmable addend to incoming beats,
// buffers the results in a small FIFO, and a round-robin arbiter merges them onto one port.
module dadd_mc_core #(
    parameter int CH_NUM     = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SAT_MODE   = 0,
    localparam int CW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CH_NUM-1:0]          dadd_in_en,
    output logic [CH_NUM-1:0]          dadd_in_rdy,
    input  logic [CH_NUM*ADDR_W-1:0]   dadd_in_addr,
    input  logic [CH_NUM*DATA_W-1:0]   dadd_in,
    input  logic                       cfg_we,
    input  logic [CW-1:0]              cfg_ch,
    input  logic [DATA_W-1:0]          cfg_addend,
    output logic                       dadd_out_en,
    input  logic                       dadd_out_rdy,
    output logic [ADDR_W-1:0]          dadd_out_addr,
    output logic [DATA_W-1:0]          dadd_out,
    output logic [CW-1:0]              dadd_out_ch,
    output logic                       dadd_out_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = ADDR_W + DATA_W + 1;

    logic [CH_NUM-1:0] empty;
    logic [CH_NUM-1:0] full;
    logic [CH_NUM-1:0] push;
    logic [CH_NUM-1:0] pop;
    logic [EW-1:0]     head [CH_NUM];

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [DATA_W-1:0] addend_q, addend_d;
            logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
            logic [DATA_W:0]   add_full;
            logic [DATA_W-1:0] result;
            logic [EW-1:0]     mem [FIFO_DEPTH];

            // The sum is formed at the push so the entry already carries result and carry.
            always_comb begin
                add_full = {1'b0, dadd_in[gi*DATA_W +: DATA_W]} + {1'b0, addend_q};
                result   = add_full[DATA_W-1:0];
                if (SAT_MODE != 0 && add_full[DATA_W]) begin
                    result = '1;
                end
                addend_d = addend_q;
                if (cfg_we && cfg_ch == CW'(gi)) begin
                    addend_d = cfg_addend;
                end
                wr_ptr_d = wr_ptr_q + PW'(push[gi]);
                rd_ptr_d = rd_ptr_q + PW'(pop[gi]);
            end

            assign empty[gi]       = (wr_ptr_q == rd_ptr_q);
            assign full[gi]        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
            assign dadd_in_rdy[gi] = !full[gi] && !reset;
            assign push[gi]        = dadd_in_en[gi] && dadd_in_rdy[gi];
            assign head[gi]        = mem[rd_ptr_q[AW-1:0]];

            always_ff @(posedge clk) begin
                if (reset) begin
                    addend_q <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    addend_q <= addend_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_q[AW-1:0]] <= {dadd_in_addr[gi*ADDR_W +: ADDR_W], result, add_full[DATA_W]};
                end
            end
        end
    endgenerate

    logic [CW-1:0]     rr_q, rr_d;
    logic              out_en_q, out_en_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CW-1:0]     out_ch_q, out_ch_d;
    logic              out_ovf_q, out_ovf_d;
    logic              load;
    logic              grant_vld;
    logic [CW-1:0]     grant_idx;
    logic [CW-1:0]     scan_idx;
    logic [EW-1:0]     head_sel;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            scan_idx = CW'((int'(rr_q) + i) % CH_NUM);
            if (!grant_vld && !empty[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // The output stage refills whenever it is empty or being consumed this cycle.
    always_comb begin
        load       = !out_en_q || dadd_out_rdy;
        head_sel   = head[grant_idx];
        pop        = (load && grant_vld) ? (CH_NUM'(1) << grant_idx) : '0;
        rr_d       = rr_q;
        out_en_d   = out_en_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_ovf_d  = out_ovf_q;
        if (load) begin
            out_en_d = grant_vld;
            if (grant_vld) begin
                out_addr_d = head_sel[EW-1 -: ADDR_W];
                out_data_d = head_sel[DATA_W:1];
                out_ovf_d  = head_sel[0];
                out_ch_d   = grant_idx;
                rr_d       = (grant_idx == CW'(CH_NUM - 1)) ? '0 : grant_idx + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign dadd_out_en   = out_en_q;
    assign dadd_out_addr = out_addr_q;
    assign dadd_out      = out_data_q;
    assign dadd_out_ch   = out_ch_q;
    assign dadd_out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_dadd_mc_core.sv
// Bench for dadd_mc_core: a wrap-mode and a saturate-mode instance share stimulus and are
// compared against a transaction-level model built from per-channel queues.
`timescale 1ns/1ps
module tb_dadd_mc_core;
    localparam int CH    = 4;
    localparam int DW    = 32;
    localparam int AWD   = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     in_en = '0;
    logic [CH*AWD-1:0] in_addr = '0;
    logic [CH*DW-1:0]  in_data = '0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [DW-1:0]     cfg_addend = '0;
    logic              out_rdy = 1'b1;

    wire [CH-1:0] rdy0, rdy1;
    wire          en0, en1, ovf0, ovf1;
    wire [31:0]   addr0, addr1, data0, data1;
    wire [1:0]    ch0, ch1;

    always #5 clk = ~clk;

    dadd_mc_core #(.CH_NUM(CH), .DATA_W(DW), .ADDR_W(AWD), .FIFO_DEPTH(DEPTH), .SAT_MODE(0)) dut_wrap (
        .clk(clk), .reset(reset), .dadd_in_en(in_en), .dadd_in_rdy(rdy0),
        .dadd_in_addr(in_addr), .dadd_in(in_data), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_addend(cfg_addend), .dadd_out_en(en0), .dadd_out_rdy(out_rdy),
        .dadd_out_addr(addr0), .dadd_out(data0), .dadd_out_ch(ch0), .dadd_out_ovf(ovf0));

    dadd_mc_core #(.CH_NUM(CH), .DATA_W(DW), .ADDR_W(AWD), .FIFO_DEPTH(DEPTH), .SAT_MODE(1)) dut_sat (
        .clk(clk), .reset(reset), .dadd_in_en(in_en), .dadd_in_rdy(rdy1),
        .dadd_in_addr(in_addr), .dadd_in(in_data), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_addend(cfg_addend), .dadd_out_en(en1), .dadd_out_rdy(out_rdy),
        .dadd_out_addr(addr1), .dadd_out(data1), .dadd_out_ch(ch1), .dadd_out_ovf(ovf1));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] d_wrap;
        logic [31:0] d_sat;
        logic        ovf;
    } beat_t;

    beat_t       mq [CH][$];
    logic [31:0] m_addend [CH];
    int          m_rr;
    logic        m_en;
    beat_t       m_out;
    logic [1:0]  m_ch;
    int          vectors = 0;
    int          miscompares = 0;

    wire [143:0] got_vec = {rdy0, rdy1, en0, en1,
                            en0 ? {addr0, data0, ch0, ovf0} : 67'd0,
                            en1 ? {addr1, data1, ch1, ovf1} : 67'd0};

    function automatic logic [143:0] exp_vec();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = !reset && (mq[c].size() < DEPTH);
        return {r, r, m_en, m_en,
                m_en ? {m_out.addr, m_out.d_wrap, m_ch, m_out.ovf} : 67'd0,
                m_en ? {m_out.addr, m_out.d_sat, m_ch, m_out.ovf} : 67'd0};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            m_addend[c] = '0;
        end
        m_rr  = 0;
        m_en  = 1'b0;
        m_out = '{addr: '0, d_wrap: '0, d_sat: '0, ovf: 1'b0};
        m_ch  = '0;
    endtask

    // Advance one clock edge, applying the transaction rules to the model with the
    // inputs present at that edge, then settle 1 ns past the edge.
    task automatic tick();
        logic [CH-1:0] acc;
        logic [32:0]   s;
        beat_t         b;
        int            g;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            for (int c = 0; c < CH; c++) acc[c] = in_en[c] && (mq[c].size() < DEPTH);
            if (!m_en || out_rdy) begin
                g = -1;
                for (int i = 0; i < CH; i++)
                    if (g < 0 && mq[(m_rr + i) % CH].size() > 0) g = (m_rr + i) % CH;
                if (g >= 0) begin
                    m_out = mq[g].pop_front();
                    m_ch  = 2'(g);
                    m_en  = 1'b1;
                    m_rr  = (g + 1) % CH;
                end else begin
                    m_en = 1'b0;
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (acc[c]) begin
                    s        = {1'b0, in_data[c*DW +: DW]} + {1'b0, m_addend[c]};
                    b.addr   = in_addr[c*AWD +: AWD];
                    b.d_wrap = s[31:0];
                    b.d_sat  = s[32] ? 32'hFFFF_FFFF : s[31:0];
                    b.ovf    = s[32];
                    mq[c].push_back(b);
                end
            end
            if (cfg_we && int'(cfg_ch) < CH) m_addend[cfg_ch] = cfg_addend;
        end
        #1;
    endtask

    always @(posedge clk)
        if (!reset && en0 && out_rdy)
            $display("out ch=%0d addr=%h data_wrap=%h data_sat=%h ovf=%b", ch0, addr0, data0, data1, ovf0);

    task automatic test_reset();
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            if ({rdy0, rdy1, en0, en1, addr0, data0, ch0, ovf0, addr1, data1, ch1, ovf1} !== '0) begin
                $display("FAIL reset_outputs cyc %0d got rdy=%h/%h en=%b/%b data=%h/%h", n, rdy0, rdy1, en0, en1, data0, data1);
                miscompares++;
            end
            vectors++;
        end
        reset = 1'b0;
        #1;
        if ({rdy0, rdy1, en0, en1} !== {4'hF, 4'hF, 2'b00}) begin
            $display("FAIL reset_release got rdy=%h/%h en=%b/%b want rdy=f/f en=0/0", rdy0, rdy1, en0, en1);
            miscompares++;
        end
        vectors++;
        tick();
        if (got_vec !== exp_vec() || en0 !== 1'b0) begin
            $display("FAIL reset_first_cycle got %h want %h", got_vec, exp_vec());
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_drain();
        in_en = '0; cfg_we = 1'b0; out_rdy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (got_vec !== exp_vec()) begin
                $display("FAIL drain cyc %0d got %h want %h", n, got_vec, exp_vec());
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_single_beat();
        out_rdy = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_addend = 32'h10;
        tick();
        cfg_we = 1'b0;
        in_en = 4'b0100; in_addr[2*AWD +: AWD] = 32'h100; in_data[2*DW +: DW] = 32'h5;
        tick();
        in_en = '0;
        if (en0 !== 1'b0) begin
            $display("FAIL single_early got en=%b want 0", en0);
            miscompares++;
        end
        vectors++;
        tick();
        if ({en0, addr0, data0, ch0, ovf0, en1, data1, ovf1} !== {1'b1, 32'h100, 32'h15, 2'd2, 1'b0, 1'b1, 32'h15, 1'b0}) begin
            $display("FAIL single_beat got en=%b addr=%h data=%h/%h ch=%0d ovf=%b want en=1 addr=100 data=15 ch=2 ovf=0",
                     en0, addr0, data0, data1, ch0, ovf0);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_overflow();
        out_rdy = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addend = 32'h2;
        tick();
        cfg_we = 1'b0;
        in_en = 4'b0001; in_addr[0 +: AWD] = 32'hABC0; in_data[0 +: DW] = 32'hFFFF_FFFF;
        tick();
        in_en = '0;
        tick();
        if ({en0, data0, ovf0} !== {1'b1, 32'h1, 1'b1}) begin
            $display("FAIL ovf_wrap got en=%b data=%h ovf=%b want en=1 data=00000001 ovf=1", en0, data0, ovf0);
            miscompares++;
        end
        vectors++;
        if ({en1, data1, ovf1} !== {1'b1, 32'hFFFF_FFFF, 1'b1}) begin
            $display("FAIL ovf_sat got en=%b data=%h ovf=%b want en=1 data=ffffffff ovf=1", en1, data1, ovf1);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_round_robin();
        int cnt [CH];
        int outs;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < CH; c++) begin
            cnt[c] = 0;
            cfg_we = 1'b1; cfg_ch = 2'(c); cfg_addend = $urandom;
            tick();
        end
        cfg_we = 1'b0; out_rdy = 1'b1; outs = 0;
        for (int n = 0; n < 200 && outs < 40; n++) begin
            in_en = 4'hF;
            for (int c = 0; c < CH; c++) begin
                in_addr[c*AWD +: AWD] = $urandom;
                in_data[c*DW +: DW]   = $urandom;
            end
            tick();
            if (got_vec !== exp_vec()) begin
                $display("FAIL rr_model cyc %0d got %h want %h", n, got_vec, exp_vec());
                miscompares++;
            end
            vectors++;
            if (en0) begin
                if (ch0 !== 2'(outs % CH)) begin
                    $display("FAIL rr_order out %0d got ch=%0d want ch=%0d", outs, ch0, outs % CH);
                    miscompares++;
                end
                vectors++;
                cnt[ch0]++;
                outs++;
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (cnt[c] !== 10) begin
                $display("FAIL rr_share ch %0d got %0d outputs want 10", c, cnt[c]);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addend;
        logic [63:0] expq [$];
        int          accepted;
        addend = $urandom;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addend = addend;
        tick();
        cfg_we = 1'b0; out_rdy = 1'b0; accepted = 0;
        for (int n = 0; n < 10; n++) begin
            in_en = 4'b0001;
            in_addr[0 +: AWD] = $urandom;
            in_data[0 +: DW]  = $urandom;
            if (rdy0[0]) begin
                accepted++;
                expq.push_back({in_addr[0 +: AWD], in_data[0 +: DW] + addend});
            end
            tick();
            if (got_vec !== exp_vec()) begin
                $display("FAIL bp_hold cyc %0d got %h want %h", n, got_vec, exp_vec());
                miscompares++;
            end
            vectors++;
        end
        in_en = '0;
        if (accepted !== DEPTH + 1 || rdy0[0] !== 1'b0) begin
            $display("FAIL bp_full got accepted=%0d rdy0=%b want accepted=%0d rdy0=0", accepted, rdy0[0], DEPTH + 1);
            miscompares++;
        end
        vectors++;
        out_rdy = 1'b1;
        for (int n = 0; n < 20 && expq.size() > 0; n++) begin
            if (en0) begin
                if ({addr0, data0} !== expq[0]) begin
                    $display("FAIL bp_drain beat %0d got %h want %h", n, {addr0, data0}, expq[0]);
                    miscompares++;
                end
                vectors++;
                void'(expq.pop_front());
            end
            tick();
        end
        if (expq.size() !== 0 || en0 !== 1'b0) begin
            $display("FAIL bp_complete got left=%0d en=%b want left=0 en=0", expq.size(), en0);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_cfg_collision();
        out_rdy = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_addend = 32'h0;
        tick();
        cfg_addend = 32'h7;
        in_en = 4'b0010; in_addr[AWD +: AWD] = 32'h40; in_data[DW +: DW] = 32'h1;
        tick();
        cfg_we = 1'b0; in_addr[AWD +: AWD] = 32'h44;
        tick();
        in_en = '0;
        if ({en0, ch0, data0, data1} !== {1'b1, 2'd1, 32'h1, 32'h1}) begin
            $display("FAIL cfg_old_addend got en=%b ch=%0d data=%h want en=1 ch=1 data=00000001", en0, ch0, data0);
            miscompares++;
        end
        vectors++;
        tick();
        if ({en0, ch0, data0, data1} !== {1'b1, 2'd1, 32'h8, 32'h8}) begin
            $display("FAIL cfg_new_addend got en=%b ch=%0d data=%h want en=1 ch=1 data=00000008", en0, ch0, data0);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_en = 4'($urandom);
            for (int c = 0; c < CH; c++) begin
                in_addr[c*AWD +: AWD] = $urandom;
                in_data[c*DW +: DW]   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            end
            out_rdy    = ($urandom_range(0, 9) < 7);
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_ch     = 2'($urandom);
            cfg_addend = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 31));
            reset      = (n >= 200 && n < 202);
            tick();
            if (got_vec !== exp_vec()) begin
                $display("FAIL random cyc %0d got %h want %h", n, got_vec, exp_vec());
                miscompares++;
            end
            vectors++;
        end
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_beat();
        test_drain();
        test_overflow();
        test_drain();
        test_round_robin();
        test_drain();
        test_backpressure();
        test_drain();
        test_cfg_collision();
        test_drain();
        test_random();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dadd_mc_core.md
# dadd_mc_core

Multi-channel successor to the single-channel data-add unit. Accepts address/data beats on `CH_NUM` independent input channels, adds a per-channel programmable addend with wrap or unsigned-saturate arithmetic, buffers results in per-channel FIFOs, and merges them round-robin onto one output port with ready/valid backpressure. It sits between the channel front-ends and the shared downstream write path. The same bench harness drives it, with the master clocking block extended for the ready signals.

## Interface
Parameters:
- `CH_NUM`, 4: number of input channels (≥1).
- `DATA_W`, 32: data and addend width.
- `ADDR_W`, 32: address width; the address passes through unmodified.
- `FIFO_DEPTH`, 4: entries per channel FIFO; a power of two, ≥2.
- `SAT_MODE`, 0: 0 = modulo 2^DATA_W wrap; 1 = unsigned saturate to all-ones.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `dadd_in_en`  in  CH_NUM  per-channel input valid.
- `dadd_in_rdy`  out  CH_NUM  per-channel input ready.
- `dadd_in_addr`  in  CH_NUM*ADDR_W  channel c occupies bits [c*ADDR_W +: ADDR_W].
- `dadd_in`  in  CH_NUM*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- `cfg_we`  in  1  addend write strobe.
- `cfg_ch`  in  max(1,$clog2(CH_NUM))  addend channel select.
- `cfg_addend`  in  DATA_W  addend value.
- `dadd_out_en`  out  1  output valid.
- `dadd_out_rdy`  in  1  downstream ready.
- `dadd_out_addr`  out  ADDR_W  passed-through address.
- `dadd_out`  out  DATA_W  sum.
- `dadd_out_ch`  out  max(1,$clog2(CH_NUM))  source channel.
- `dadd_out_ovf`  out  1  the sum overflowed (carry-out set), in either mode.

## Operation
- **Input accept:** on channel c, a beat is accepted at an edge where `dadd_in_en[c] & dadd_in_rdy[c]`.
  - `dadd_in_rdy[c] = !full[c] & !reset`. This is combinational; a pop in the same cycle does not free space for a push.
- **Add:** `{carry, sum} = dadd_in[c] + addend[c]` is computed at the write.
  - The FIFO entry stores {addr, result, carry}.
  - result = sum when SAT_MODE=0; result = carry ? all-ones : sum when SAT_MODE=1.
- **Config:** when `cfg_we` is high, `addend[cfg_ch]` is updated at the edge.
  - A beat accepted in the same cycle on that channel uses the OLD addend.
  - A `cfg_ch` ≥ CH_NUM is ignored.
- **Output register:** a single stage holding `dadd_out_*`.
  - It loads when it is empty or when `dadd_out_rdy` is high.
  - If no FIFO is non-empty when it frees, `dadd_out_en` drops to 0.
- **Arbitration:** round-robin pointer `rr`.
  - The grant goes to the first non-empty FIFO scanning rr, rr+1, … modulo CH_NUM.
  - On a grant to g, that FIFO is popped and `rr <= (g+1) mod CH_NUM`.
  - `rr` does not move when there is no grant.
- **Hold:** while `dadd_out_en & !dadd_out_rdy`, all `dadd_out_*` stay stable and no FIFO pops.
- **FIFO pointers:** the wrap at FIFO_DEPTH uses an extra pointer MSB for full/empty detection.

## Timing
- **Reset:** while `reset` is high at an edge:
  - all FIFOs are emptied, addends are set to 0 and `rr` is set to 0;
  - `dadd_out_en`, `dadd_out_addr`, `dadd_out`, `dadd_out_ch` and `dadd_out_ovf` are all 0;
  - `dadd_in_rdy` is 0 throughout reset.
- **Reset mid-operation:** all buffered beats are discarded; nothing is emitted after reset.
- **Latency:** a beat accepted at edge N appears with `dadd_out_en=1` after edge N+1, provided its channel wins arbitration and the output register is free.
- **Throughput:** one output per cycle when `dadd_out_rdy` is held high; up to one input per channel per cycle.
- **Full:** `FIFO_DEPTH` beats buffered on a channel → its `dadd_in_rdy` is low the following cycle. It goes high again the cycle after a pop from that FIFO.
- **Contention:** with all channels continuously non-empty, the output channel sequence is 0,1,…,CH_NUM-1,0,…

## Test plan
1. **Reset values:** hold reset 3 cycles, then release → all outputs are 0 during reset, `dadd_in_rdy` goes all-ones on the first cycle after release, and `dadd_out_en` stays 0.
2. **Single beat:** set `addend[2]=0x10`. Send ch2 addr 0x100, data 0x5 at edge N → after N+1: `dadd_out_en`=1, addr 0x100, data 0x15, ch 2, ovf 0.
3. **Overflow, both modes:** addend 0x2, data 0xFFFFFFFF.
   - SAT_MODE=0 → out 0x00000001, ovf 1.
   - SAT_MODE=1 → out 0xFFFFFFFF, ovf 1.
4. **Round-robin fairness:** drive all 4 channels every cycle with `dadd_out_rdy`=1 → ch order 0,1,2,3,0,…; each channel gets exactly 1/4 of the outputs.
5. **Backpressure/full:**
   - Hold `dadd_out_rdy`=0 and push ch0 continuously → the first beat is held in the output register, ch0 accepts FIFO_DEPTH more beats, then `dadd_in_rdy[0]`=0, and the output stays stable.
   - Release `rdy` → all beats drain in order with no loss or duplication.
6. **Config/push collision:** `cfg_we` to ch1 with 0x7 while a ch1 beat (data 0x1, old addend 0x0) is accepted → that output is 0x1; the next beat with data 0x1 → 0x8.
